// File: rtl/rf_seq.sv
// rf_seq: two-stage (Read / Execute-Write) instruction sequencer
// driving the rf read/write ports, with EX->R operand forwarding.
module rf_seq #(
    parameter int bw = 8,
    parameter int aw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [aw-1:0] in_rd,
    input  logic [aw-1:0] in_ra,
    input  logic [aw-1:0] in_rb,
    input  logic [bw-1:0] in_imm,
    output logic [aw-1:0] rf_ra,
    output logic [aw-1:0] rf_rb,
    input  logic [bw-1:0] rf_a,
    input  logic [bw-1:0] rf_b,
    output logic [aw-1:0] rf_rd,
    output logic [bw-1:0] rf_d,
    output logic          rf_writed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [bw-1:0] out_data
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LDI = 2'b10,
        OP_RD  = 2'b11
    } op_e;

    logic          ex_valid_q, ex_valid_d;
    op_e           ex_op_q, ex_op_d;
    logic [aw-1:0] ex_rd_q, ex_rd_d;
    logic [bw-1:0] ex_a_q, ex_a_d;
    logic [bw-1:0] ex_b_q, ex_b_d;
    logic [bw-1:0] ex_imm_q, ex_imm_d;

    logic          ex_wr;
    logic          ex_adv;
    logic          accept;
    logic [bw-1:0] ex_res;
    logic [bw-1:0] op_a;
    logic [bw-1:0] op_b;

    // EX result, forwarding muxes, flow control and EX next-state
    always_comb begin
        unique case (ex_op_q)
            OP_ADD:  ex_res = ex_a_q + ex_b_q;
            OP_SUB:  ex_res = ex_a_q - ex_b_q;
            OP_LDI:  ex_res = ex_imm_q;
            default: ex_res = ex_a_q;
        endcase

        ex_wr  = ex_valid_q && (ex_op_q != OP_RD);
        op_a   = (ex_wr && ex_rd_q == in_ra) ? ex_res : rf_a;
        op_b   = (ex_wr && ex_rd_q == in_rb) ? ex_res : rf_b;

        ex_adv = !ex_valid_q || (ex_op_q != OP_RD) || out_ready;
        accept = in_valid && ex_adv;

        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;

        if (accept) begin
            ex_valid_d = 1'b1;
            ex_op_d    = op_e'(in_op);
            ex_rd_d    = in_rd;
            ex_a_d     = op_a;
            ex_b_d     = op_b;
            ex_imm_d   = in_imm;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end
    end

    // EX pipeline register; reset drops any pending write or result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= OP_ADD;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
        end
    end

    assign rf_ra     = in_ra;
    assign rf_rb     = in_rb;
    assign rf_rd     = ex_rd_q;
    assign rf_d      = ex_res;
    assign rf_writed = ex_wr;
    assign out_valid = ex_valid_q && (ex_op_q == OP_RD);
    assign out_data  = ex_a_q;
    assign in_ready  = ex_adv;

endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq: scoreboard bench for rf_seq with a behavioural rf
// attached; expectations come from an architectural register model.
module tb_rf_seq;

    localparam int BW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_rd, in_ra, in_rb;
    logic [BW-1:0] in_imm;
    logic [AW-1:0] rf_ra, rf_rb, rf_rd;
    logic [BW-1:0] rf_a, rf_b, rf_d;
    logic          rf_writed;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [BW-1:0] regs [16];
    logic [BW-1:0] shadow [16];
    logic [AW+BW-1:0] wq [$];
    logic [BW-1:0]    oq [$];

    rf_seq #(.bw(BW), .aw(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_imm    (in_imm),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_a      (rf_a),
        .rf_b      (rf_b),
        .rf_rd     (rf_rd),
        .rf_d      (rf_d),
        .rf_writed (rf_writed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural register file, cleared by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (rf_writed) begin
            regs[rf_rd] <= rf_d;
        end
    end

    assign rf_a = regs[rf_ra];
    assign rf_b = regs[rf_rb];

    // scoreboard monitor: every write and every RD handshake is popped
    always @(negedge clk) begin
        if (rst) begin
            if (rf_writed) begin
                n_checks++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got rd=%0d d=%h, none expected",
                             rf_rd, rf_d);
                end else begin
                    logic [AW+BW-1:0] e;
                    e = wq.pop_front();
                    if ({rf_rd, rf_d} !== e) begin
                        n_fail++;
                        $display("FAIL write: got rd=%0d d=%h, expected rd=%0d d=%h",
                                 rf_rd, rf_d, e[AW+BW-1:BW], e[BW-1:0]);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (oq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got %h, none expected", out_data);
                end else begin
                    logic [BW-1:0] e;
                    e = oq.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL result: got %h, expected %h", out_data, e);
                    end
                end
            end
        end
    end

    // offer one instruction, wait for acceptance, record expectations
    task automatic issue(input logic [1:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [7:0] imm);
        int n = 0;
        logic [7:0] r;
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        case (op)
            2'b00: r = shadow[ra] + shadow[rb];
            2'b01: r = shadow[ra] - shadow[rb];
            2'b10: r = imm;
            default: r = shadow[ra];
        endcase
        if (op == 2'b11) oq.push_back(r);
        else begin
            wq.push_back({rd, r});
            shadow[rd] = r;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n = 0;
        out_ready = 1'b1;
        while ((wq.size() != 0 || oq.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (wq.size() != 0 || oq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d writes %0d results outstanding, required 0",
                     wq.size(), oq.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rb = '0; in_imm = '0;
        in_ra = 4'd5;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, rf_writed} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/ovalid/wr=%b, expected 100",
                     {in_ready, out_valid, rf_writed});
        end
        n_checks++;
        if ({rf_rd, rf_d, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rd=%0d d=%h out=%h, expected 0",
                     rf_rd, rf_d, out_data);
        end
        n_checks++;
        if (rf_ra !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_ra: got %0d, expected 5", rf_ra);
        end
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        issue(2'b10, 4'd3, 4'd0, 4'd0, 8'h5A);
        idle(1);
        issue(2'b11, 4'd0, 4'd3, 4'd0, 8'h00);
        drain();
    endtask

    task automatic test_back_to_back;
        issue(2'b10, 4'd1, 4'd0, 4'd0, 8'h10);
        issue(2'b10, 4'd2, 4'd0, 4'd0, 8'h22);
        issue(2'b00, 4'd4, 4'd1, 4'd2, 8'h00);
        issue(2'b11, 4'd0, 4'd4, 4'd0, 8'h00);
        drain();
    endtask

    task automatic test_modular;
        issue(2'b10, 4'd5, 4'd0, 4'd0, 8'hF0);
        issue(2'b10, 4'd6, 4'd0, 4'd0, 8'h20);
        issue(2'b00, 4'd7, 4'd5, 4'd6, 8'h00);
        issue(2'b01, 4'd8, 4'd6, 4'd5, 8'h00);
        issue(2'b01, 4'd9, 4'd5, 4'd5, 8'h00);
        issue(2'b11, 4'd0, 4'd7, 4'd0, 8'h00);
        issue(2'b11, 4'd0, 4'd8, 4'd0, 8'h00);
        issue(2'b11, 4'd0, 4'd9, 4'd0, 8'h00);
        drain();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(2'b11, 4'd0, 4'd3, 4'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid} !== 2'b01 || out_data !== 8'h5A) begin
                n_fail++;
                $display("FAIL stall_%0d: got ready/ovalid=%b data=%h, expected 01 5a",
                         i, {in_ready, out_valid}, out_data);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL release: got ready/ovalid=%b, expected 11",
                     {in_ready, out_valid});
        end
        issue(2'b10, 4'd10, 4'd0, 4'd0, 8'hA5);
        drain();
    endtask

    task automatic test_reset_mid;
        issue(2'b10, 4'd2, 4'd0, 4'd0, 8'h77);
        n_checks++;
        if (rf_writed !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: rf_writed=%b, expected 1", rf_writed);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rf_writed, out_valid, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL mid_reset: got wr/ovalid/ready=%b, expected 001",
                     {rf_writed, out_valid, in_ready});
        end
        wq.delete();
        oq.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        issue(2'b11, 4'd0, 4'd2, 4'd0, 8'h00);
        issue(2'b11, 4'd0, 4'd3, 4'd0, 8'h00);
        drain();
    endtask

    task automatic test_sweep;
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        for (int n = 0; n < 16; n++)
            issue(2'b10, 4'(n), 4'd0, 4'd0, 8'(n * 8'h11));
        for (int n = 0; n < 16; n++)
            issue(2'b11, 4'd0, 4'(n), 4'd0, 8'h00);
        n_checks++;
        if (cyc - c0 !== 32) begin
            n_fail++;
            $display("FAIL throughput: took %0d cycles, expected 32", cyc - c0);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_modular();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
